// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state and forwarding codes,
// register-address width, PC index and branch-penalty bounds.
package pipe_ctrl_pkg;

   localparam int unsigned REGAW = 4;
   localparam logic [REGAW-1:0] PC_IDX = 4'd15;

   localparam int unsigned BR_PENALTY_MIN = 1;
   localparam int unsigned BR_PENALTY_MAX = 3;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_BRANCH  = 2'd1,
      ST_MEMWAIT = 2'd2,
      ST_ILLEGAL = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   // Cycles spent in BRANCH after the redirect cycle; out-of-range penalties are clamped.
   function automatic logic [1:0] br_reload(input int unsigned penalty);
      int unsigned p;
      p = penalty;
      if (p < BR_PENALTY_MIN) p = BR_PENALTY_MIN;
      if (p > BR_PENALTY_MAX) p = BR_PENALTY_MAX;
      return 2'(p - 1);
   endfunction

endpackage

// File: rtl/pipe_ctrl_fwdsel.sv
// Forwarding-source select for one ID-stage source operand.
module pipe_ctrl_fwdsel
   import pipe_ctrl_pkg::*;
(
   input  logic             src_used,
   input  logic [REGAW-1:0] src_a,
   input  logic             ex_v,
   input  logic             ex_we,
   input  logic             ex_ld,
   input  logic [REGAW-1:0] ex_rd,
   input  logic             mem_v,
   input  logic             mem_we,
   input  logic [REGAW-1:0] mem_rd,
   output logic [1:0]       sel
);

   // A load in EX has no data yet; that case is covered by the load-use stall.
   always_comb begin
      sel = FWD_RF;
      if (src_used && (src_a != PC_IDX)) begin
         if (ex_v && ex_we && !ex_ld && (src_a == ex_rd))
            sel = FWD_EX;
         else if (mem_v && mem_we && (src_a == mem_rd))
            sel = FWD_MEM;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stage enables, flushes, forwarding selects,
// branch penalty / memory-wait FSM and a saturating stall counter.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned BR_PENALTY = 2,
   parameter int unsigned STALLCNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid_in,
   input  logic [REGAW-1:0]      id_rn_a_in,
   input  logic [REGAW-1:0]      id_rm_a_in,
   input  logic [REGAW-1:0]      id_rd_a_in,
   input  logic                  id_rm_used_in,
   input  logic                  id_reg_we_in,
   input  logic                  id_ib_in,
   input  logic                  id_ldstr_in,
   input  logic                  ex_cond_pass_in,
   input  logic                  mem_ready_in,
   output logic                  pc_we_out,
   output logic                  pc_sel_out,
   output logic                  ifid_we_out,
   output logic                  ifid_flush_out,
   output logic                  idex_we_out,
   output logic                  idex_bubble_out,
   output logic                  exmem_we_out,
   output logic [1:0]            fwd_rn_sel_out,
   output logic [1:0]            fwd_rm_sel_out,
   output logic [1:0]            state_out,
   output logic [STALLCNT_W-1:0] stall_cnt_out
);

   localparam logic [1:0] BR_RELOAD = br_reload(BR_PENALTY);

   state_t           state_q, state_d;
   logic [1:0]       br_cnt_q, br_cnt_d;

   logic             ex_v, ex_we, ex_ld, ex_br;
   logic [REGAW-1:0] ex_rd;
   logic             mem_v, mem_we, mem_ldstr;
   logic [REGAW-1:0] mem_rd;

   logic             hold, taken, pending, load_use;

   assign hold     = mem_v & mem_ldstr & ~mem_ready_in;
   assign taken    = ex_v & ex_br & ex_cond_pass_in;
   assign pending  = (br_cnt_q != 2'd0);
   assign load_use = id_valid_in & ex_v & ex_ld & ex_we &
                     ((id_rn_a_in == ex_rd) | (id_rm_used_in & (id_rm_a_in == ex_rd)));

   // The remaining penalty lives in br_cnt_q, so a memory wait freezes it and
   // the flush sequence resumes once the access completes.
   always_comb begin
      pc_we_out       = 1'b0;
      pc_sel_out      = 1'b0;
      ifid_we_out     = 1'b0;
      ifid_flush_out  = 1'b0;
      idex_we_out     = 1'b0;
      idex_bubble_out = 1'b0;
      exmem_we_out    = 1'b0;
      br_cnt_d        = br_cnt_q;
      if (rst_n && !hold) begin
         idex_we_out  = 1'b1;
         exmem_we_out = 1'b1;
         if (taken) begin
            pc_we_out       = 1'b1;
            pc_sel_out      = 1'b1;
            ifid_we_out     = 1'b1;
            ifid_flush_out  = 1'b1;
            idex_bubble_out = 1'b1;
            br_cnt_d        = BR_RELOAD;
         end else if (pending) begin
            pc_we_out       = 1'b1;
            ifid_we_out     = 1'b1;
            ifid_flush_out  = 1'b1;
            idex_bubble_out = 1'b1;
            br_cnt_d        = br_cnt_q - 2'd1;
         end else if (load_use) begin
            idex_bubble_out = 1'b1;
         end else begin
            pc_we_out   = 1'b1;
            ifid_we_out = 1'b1;
         end
      end
   end

   always_comb begin
      if (state_q == ST_ILLEGAL)
         state_d = ST_RUN;
      else if (hold)
         state_d = ST_MEMWAIT;
      else if (br_cnt_d != 2'd0)
         state_d = ST_BRANCH;
      else
         state_d = ST_RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         br_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         br_cnt_q <= br_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_v      <= 1'b0;
         ex_we     <= 1'b0;
         ex_ld     <= 1'b0;
         ex_br     <= 1'b0;
         ex_rd     <= '0;
         mem_v     <= 1'b0;
         mem_we    <= 1'b0;
         mem_ldstr <= 1'b0;
         mem_rd    <= '0;
      end else begin
         if (idex_we_out) begin
            ex_v  <= id_valid_in & ~idex_bubble_out;
            ex_we <= id_reg_we_in;
            ex_ld <= id_ldstr_in;
            ex_br <= id_ib_in;
            ex_rd <= id_rd_a_in;
         end
         if (exmem_we_out) begin
            mem_v     <= ex_v;
            mem_we    <= ex_we;
            mem_ldstr <= ex_ld;
            mem_rd    <= ex_rd;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_out <= '0;
      else if (!pc_we_out && (stall_cnt_out != '1))
         stall_cnt_out <= stall_cnt_out + STALLCNT_W'(1);
   end

   assign state_out = state_q;

   pipe_ctrl_fwdsel u_fwd_rn (
      .src_used (1'b1),
      .src_a    (id_rn_a_in),
      .ex_v     (ex_v),
      .ex_we    (ex_we),
      .ex_ld    (ex_ld),
      .ex_rd    (ex_rd),
      .mem_v    (mem_v),
      .mem_we   (mem_we),
      .mem_rd   (mem_rd),
      .sel      (fwd_rn_sel_out)
   );

   pipe_ctrl_fwdsel u_fwd_rm (
      .src_used (id_rm_used_in),
      .src_a    (id_rm_a_in),
      .ex_v     (ex_v),
      .ex_we    (ex_we),
      .ex_ld    (ex_ld),
      .ex_rd    (ex_rd),
      .mem_v    (mem_v),
      .mem_we   (mem_we),
      .mem_rd   (mem_rd),
      .sel      (fwd_rm_sel_out)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid, id_rm_used, id_reg_we, id_ib, id_ldstr;
   logic [3:0]  id_rn, id_rm, id_rd;
   logic        ex_cond_pass, mem_ready;
   logic        pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we;
   logic [1:0]  fwd_rn, fwd_rm, state;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   pipe_ctrl #(.BR_PENALTY(2), .STALLCNT_W(16)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_valid_in     (id_valid),
      .id_rn_a_in      (id_rn),
      .id_rm_a_in      (id_rm),
      .id_rd_a_in      (id_rd),
      .id_rm_used_in   (id_rm_used),
      .id_reg_we_in    (id_reg_we),
      .id_ib_in        (id_ib),
      .id_ldstr_in     (id_ldstr),
      .ex_cond_pass_in (ex_cond_pass),
      .mem_ready_in    (mem_ready),
      .pc_we_out       (pc_we),
      .pc_sel_out      (pc_sel),
      .ifid_we_out     (ifid_we),
      .ifid_flush_out  (ifid_flush),
      .idex_we_out     (idex_we),
      .idex_bubble_out (idex_bubble),
      .exmem_we_out    (exmem_we),
      .fwd_rn_sel_out  (fwd_rn),
      .fwd_rm_sel_out  (fwd_rm),
      .state_out       (state),
      .stall_cnt_out   (stall_cnt)
   );

   // ctl bit order: pc_we pc_sel ifid_we ifid_flush idex_we idex_bubble exmem_we
   localparam logic [6:0] C_OFF   = 7'b0000000;
   localparam logic [6:0] C_NORM  = 7'b1010101;
   localparam logic [6:0] C_LU    = 7'b0000111;
   localparam logic [6:0] C_TAKEN = 7'b1111111;
   localparam logic [6:0] C_PEN   = 7'b1011111;
   localparam logic [1:0] S_RUN = 2'd0, S_BR = 2'd1, S_MW = 2'd2;

   typedef struct {
      string       name;
      logic [28:0] exp;
   } chk_t;

   chk_t        sb[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [28:0] obs;

   assign obs = {pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we,
                 fwd_rn, fwd_rm, state, stall_cnt};

   always @(negedge clk) begin
      chk_t c;
      if (sb.size() > 0) begin
         c = sb.pop_front();
         n_checks++;
         if (obs !== c.exp) begin
            n_errors++;
            $display("FAIL %s: actual ctl=%b rn=%b rm=%b st=%0d cnt=%0d, required ctl=%b rn=%b rm=%b st=%0d cnt=%0d",
                     c.name, obs[28:22], obs[21:20], obs[19:18], obs[17:16], obs[15:0],
                     c.exp[28:22], c.exp[21:20], c.exp[19:18], c.exp[17:16], c.exp[15:0]);
         end
      end
   end

   task automatic set_id(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [3:0] rd, input logic used, input logic we,
                         input logic ib, input logic ls);
      id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
      id_rm_used = used; id_reg_we = we; id_ib = ib; id_ldstr = ls;
   endtask

   task automatic idle();
      set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Push the expected outputs for the current cycle, then advance one cycle.
   task automatic step(input string name, input logic [6:0] ctl, input logic [1:0] rn,
                       input logic [1:0] rm, input logic [1:0] st, input logic [15:0] cnt);
      chk_t c;
      c.name = name;
      c.exp  = {ctl, rn, rm, st, cnt};
      sb.push_back(c);
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      ex_cond_pass = 1'b0;
      mem_ready    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      step("reset", C_OFF, 2'b00, 2'b00, S_RUN, 16'd0);
      rst_n = 1'b1;

      // forwarding
      set_id(1, 4'd2, 4'd3, 4'd1, 1, 1, 0, 0);   step("add_r1",     C_NORM, 2'b00, 2'b00, S_RUN, 16'd0);
      set_id(1, 4'd1, 4'd3, 4'd2, 1, 1, 0, 0);   step("sub_fwd_ex", C_NORM, 2'b01, 2'b00, S_RUN, 16'd0);
      set_id(1, 4'd2, 4'd1, 4'd7, 1, 1, 0, 0);   step("fwd_ex_mem", C_NORM, 2'b01, 2'b10, S_RUN, 16'd0);
      set_id(1, 4'd7, 4'd2, 4'd8, 0, 1, 0, 0);   step("rm_unused",  C_NORM, 2'b01, 2'b00, S_RUN, 16'd0);
      set_id(1, 4'd0, 4'd0, 4'd15, 0, 1, 0, 0);  step("wr_pc",      C_NORM, 2'b00, 2'b00, S_RUN, 16'd0);
      set_id(1, 4'd15, 4'd15, 4'd9, 1, 0, 0, 0); step("pc_no_fwd",  C_NORM, 2'b00, 2'b00, S_RUN, 16'd0);
      set_id(0, 4'd9, 4'd0, 4'd0, 0, 0, 0, 0);   step("ex_no_we",   C_NORM, 2'b00, 2'b00, S_RUN, 16'd0);

      // load-use
      set_id(1, 4'd0, 4'd0, 4'd4, 0, 1, 0, 1);   step("ldr",        C_NORM, 2'b00, 2'b00, S_RUN, 16'd0);
      set_id(1, 4'd4, 4'd4, 4'd5, 1, 1, 0, 0);   step("load_use",   C_LU,   2'b00, 2'b00, S_RUN, 16'd0);
                                                  step("after_lu",   C_NORM, 2'b10, 2'b10, S_RUN, 16'd1);
      idle();                                     step("lu_drain",   C_NORM, 2'b00, 2'b00, S_RUN, 16'd1);

      // taken and untaken branch
      set_id(1, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0);   step("b_id",       C_NORM, 2'b00, 2'b00, S_RUN, 16'd1);
      set_id(1, 4'd1, 4'd0, 4'd10, 0, 1, 0, 0);
      ex_cond_pass = 1'b1;                        step("b_taken",    C_TAKEN, 2'b00, 2'b00, S_RUN, 16'd1);
      set_id(1, 4'd1, 4'd0, 4'd11, 0, 1, 0, 0);
      ex_cond_pass = 1'b0;                        step("b_penalty",  C_PEN,  2'b00, 2'b00, S_BR,  16'd1);
      idle();                                     step("b_done",     C_NORM, 2'b00, 2'b00, S_RUN, 16'd1);
      set_id(1, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0);   step("bn_id",      C_NORM, 2'b00, 2'b00, S_RUN, 16'd1);
      idle();                                     step("b_untaken",  C_NORM, 2'b00, 2'b00, S_RUN, 16'd1);
                                                  step("bn_drain",   C_NORM, 2'b00, 2'b00, S_RUN, 16'd1);

      // memory wait on a store (fresh reset so the stall count starts at zero)
      rst_n = 1'b0;                               step("mid_reset",  C_OFF,  2'b00, 2'b00, S_RUN, 16'd0);
      rst_n = 1'b1;
      set_id(1, 4'd1, 4'd2, 4'd3, 1, 0, 0, 1);   step("str_id",     C_NORM, 2'b00, 2'b00, S_RUN, 16'd0);
      idle();                                     step("str_ex",     C_NORM, 2'b00, 2'b00, S_RUN, 16'd0);
      mem_ready = 1'b0;                           step("mw_enter",   C_OFF,  2'b00, 2'b00, S_RUN, 16'd0);
                                                  step("mw_1",       C_OFF,  2'b00, 2'b00, S_MW,  16'd1);
                                                  step("mw_2",       C_OFF,  2'b00, 2'b00, S_MW,  16'd2);
      mem_ready = 1'b1;                           step("mw_release", C_NORM, 2'b00, 2'b00, S_MW,  16'd3);
                                                  step("mw_run",     C_NORM, 2'b00, 2'b00, S_RUN, 16'd3);

      // taken branch in EX while the store ahead of it waits on memory
      set_id(1, 4'd1, 4'd2, 4'd3, 1, 0, 0, 1);   step("str2_id",    C_NORM, 2'b00, 2'b00, S_RUN, 16'd3);
      set_id(1, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0);   step("b2_id",      C_NORM, 2'b00, 2'b00, S_RUN, 16'd3);
      set_id(1, 4'd1, 4'd0, 4'd12, 0, 1, 0, 0);
      ex_cond_pass = 1'b1;
      mem_ready = 1'b0;                           step("defer_0",    C_OFF,  2'b00, 2'b00, S_RUN, 16'd3);
                                                  step("defer_1",    C_OFF,  2'b00, 2'b00, S_MW,  16'd4);
      mem_ready = 1'b1;                           step("defer_taken", C_TAKEN, 2'b00, 2'b00, S_MW, 16'd5);
      ex_cond_pass = 1'b0;                        step("defer_pen",  C_PEN,  2'b00, 2'b00, S_BR,  16'd5);
      idle();                                     step("defer_done", C_NORM, 2'b00, 2'b00, S_RUN, 16'd5);

      // reset asserted while in BRANCH
      set_id(1, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0);   step("b3_id",      C_NORM, 2'b00, 2'b00, S_RUN, 16'd5);
      set_id(1, 4'd1, 4'd0, 4'd13, 0, 1, 0, 0);
      ex_cond_pass = 1'b1;                        step("b3_taken",   C_TAKEN, 2'b00, 2'b00, S_RUN, 16'd5);
      ex_cond_pass = 1'b0;
      idle();
      rst_n = 1'b0;                               step("rst_in_br",  C_OFF,  2'b00, 2'b00, S_RUN, 16'd0);
      rst_n = 1'b1;                               step("rst_release", C_NORM, 2'b00, 2'b00, S_RUN, 16'd0);
                                                  step("post_reset", C_NORM, 2'b00, 2'b00, S_RUN, 16'd0);

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL drain: actual %0d unchecked entries, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout, required completion");
      $fatal(1, "timeout");
   end

endmodule
